pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Multi-cycle control FSM that sequences the program counter datapath. It fetches each instruction over a request/acknowledge handshake and classifies it as sequential, beq, bne, j or jr. For conditional branches it waits on the execute unit, then drives the PC register's branch code, select and target inputs and issues a single-cycle PC update strobe. It sits between instruction memory, the execute unit and the PC register, and owns the only write-enable of the PC.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, value the PC datapath holds after reset; ImemAddr reset value
- IMEM_TIMEOUT, 15, max wait cycles for ImemAck before Fault

Ports:
- Clk  in  1  rising-edge clock
- ReSet_n  in  1  asynchronous, active-low reset
- CurPc  in  32  current PC from PC register
- ImemReq  out  1  fetch request
- ImemAddr  out  32  fetch address (= CurPc captured on entry to FETCH)
- ImemAck  in  1  fetch done; ImemData valid this cycle
- ImemData  in  32  fetched instruction
- RsData  in  32  register-file rs read port, valid in DECODE
- ExeReq  out  1  execute-unit request (beq/bne compare)
- ExeDone  in  1  execute done; AluZero valid this cycle
- AluZero  in  1  compare result
- PcStep  out  1  one-cycle PC register enable
- Branch  out  3  111 jr, 011 j, 010 beq, 001 bne, 000 sequential
- PcSel  out  1  conditional branch taken
- JumpTarget  out  26  Ir[25:0]
- BrOffset  out  32  sign-extended Ir[15:0] (word offset)
- JrTarget  out  32  RsData latched in DECODE
- Ir  out  32  latched instruction
- InstrCount  out  32  retired instructions, wraps at 2^32
- Fault  out  1  sticky fetch fault

## Operation
- States: FETCH, DECODE, EXEC, UPDATE, FAULT.
- FETCH: ImemReq=1, ImemAddr=CurPc; timeout counter increments each cycle without ack.
  - ImemAck: latch Ir, clear counter, go to DECODE.
  - Counter reaching IMEM_TIMEOUT without ack: go to FAULT.
  - CurPc[1:0]!=0 on entry: go to FAULT, no request issued.
- DECODE: opcode Ir[31:26].
  - 6'h02 (j): Branch=011, go to UPDATE.
  - 6'h00 with funct 6'h08 (jr): Branch=111, latch JrTarget=RsData, go to UPDATE.
  - 6'h04/6'h05 (beq/bne): Branch=010/001, go to EXEC.
  - Other opcodes: Branch=000, go to EXEC.
- EXEC: ExeReq=1 until ExeDone, no timeout.
  - On ExeDone: PcSel = beq ? AluZero : bne ? ~AluZero : 0; go to UPDATE.
- UPDATE: PcStep=1 for exactly one cycle; InstrCount+1; go to FETCH.
- FAULT: all requests and PcStep are 0; Fault=1; held until reset.
- Branch, PcSel, JumpTarget, BrOffset and JrTarget are stable from their set point through UPDATE; Branch and PcSel return to 0 in FETCH.

## Timing
- Reset (async assert) outputs: ImemReq=0, ImemAddr=RESET_PC, ExeReq=0, PcStep=0, Branch=000, PcSel=0, JumpTarget=0, BrOffset=0, JrTarget=0, Ir=0, InstrCount=0, Fault=0. State is FETCH.
- First ImemReq is asserted in the first cycle after ReSet_n deasserts.
- Reset mid-instruction aborts it: no PcStep, no count.
- Latency with same-cycle ack and done:
  - j/jr: FETCH, DECODE, UPDATE = 3 cycles.
  - Others: 4 cycles.
- ImemReq drops the cycle after ImemAck; ExeReq drops the cycle after ExeDone.
- ImemAck in the same cycle the timeout is reached: ack wins.
- Ack arriving outside FETCH is ignored; so is ExeDone outside EXEC.
- Timeout counter width is clog2(IMEM_TIMEOUT+1).

## Structure
- Package mips_ctrl_pkg holds:
  - opcode/funct constants (OP_J, OP_BEQ, OP_BNE, OP_RTYPE, FN_JR)
  - Branch codes (BR_SEQ, BR_BNE, BR_BEQ, BR_J, BR_JR)
  - state enum
- Sub-module instr_classify: combinational Ir -> Branch code plus needs_exec flag.

## Test plan
- Reset release with CurPc=0x3000, ack after 2 cycles, Ir=addu -> ExeReq, ExeDone -> PcStep with Branch=000, PcSel=0, InstrCount=1.
- Ir=0x0800_0C00 (j) -> Branch=011, JumpTarget=0x000_0C00, PcStep 2 cycles after ack, ExeReq never asserted.
- beq with AluZero=1 -> PcSel=1; bne with AluZero=1 -> PcSel=0; BrOffset from Ir[15:0]=0xFFFE is 0xFFFF_FFFE.
- jr with RsData=0x0000_3010 -> Branch=111, JrTarget=0x0000_3010, PcStep once.
- No ImemAck for 15 cycles -> Fault=1, ImemReq=0; further ack ignored. CurPc=0x3002 -> immediate Fault.
- ReSet_n pulsed low during EXEC -> no PcStep, all outputs at reset values, fetch restarts.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - Opcode, branch-code and state definitions shared by the PC sequencer
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  localparam logic [2:0] BR_SEQ = 3'b000;
  localparam logic [2:0] BR_BNE = 3'b001;
  localparam logic [2:0] BR_BEQ = 3'b010;
  localparam logic [2:0] BR_J   = 3'b011;
  localparam logic [2:0] BR_JR  = 3'b111;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_UPDATE,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/instr_classify.sv
// rtl/instr_classify.sv - Maps opcode/funct to a PC branch code and an execute-needed flag
module instr_classify
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] branch,
  output logic       needs_exec
);

  always_comb begin
    branch     = BR_SEQ;
    needs_exec = 1'b1;
    case (opcode)
      OP_J: begin
        branch     = BR_J;
        needs_exec = 1'b0;
      end
      OP_BEQ: branch = BR_BEQ;
      OP_BNE: branch = BR_BNE;
      OP_RTYPE: begin
        if (funct == FN_JR) begin
          branch     = BR_JR;
          needs_exec = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - Fetch/decode/execute/update FSM that owns the PC register write-enable
module pc_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_3000,
  parameter int          IMEM_TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        ReSet_n,
  input  logic [31:0] CurPc,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemData,
  input  logic [31:0] RsData,
  output logic        ExeReq,
  input  logic        ExeDone,
  input  logic        AluZero,
  output logic        PcStep,
  output logic [2:0]  Branch,
  output logic        PcSel,
  output logic [25:0] JumpTarget,
  output logic [31:0] BrOffset,
  output logic [31:0] JrTarget,
  output logic [31:0] Ir,
  output logic [31:0] InstrCount,
  output logic        Fault
);

  localparam int CW = $clog2(IMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(IMEM_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    cls_branch;
  logic          cls_exec;

  instr_classify u_classify (
    .opcode     (Ir[31:26]),
    .funct      (Ir[5:0]),
    .branch     (cls_branch),
    .needs_exec (cls_exec)
  );

  always_ff @(posedge Clk or negedge ReSet_n) begin
    if (!ReSet_n) begin
      state      <= ST_FETCH;
      wait_cnt   <= '0;
      ImemReq    <= 1'b0;
      ImemAddr   <= RESET_PC;
      ExeReq     <= 1'b0;
      PcStep     <= 1'b0;
      Branch     <= BR_SEQ;
      PcSel      <= 1'b0;
      JumpTarget <= '0;
      BrOffset   <= '0;
      JrTarget   <= '0;
      Ir         <= '0;
      InstrCount <= '0;
      Fault      <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          // First FETCH cycle (ImemReq still low) checks alignment and captures the address
          if (!ImemReq) begin
            if (CurPc[1:0] != 2'b00) begin
              Fault <= 1'b1;
              state <= ST_FAULT;
            end else begin
              ImemReq  <= 1'b1;
              ImemAddr <= CurPc;
              wait_cnt <= '0;
            end
          end else if (ImemAck) begin
            ImemReq  <= 1'b0;
            Ir       <= ImemData;
            wait_cnt <= '0;
            state    <= ST_DECODE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt == TO_LAST) begin
              ImemReq <= 1'b0;
              Fault   <= 1'b1;
              state   <= ST_FAULT;
            end
          end
        end
        ST_DECODE: begin
          Branch     <= cls_branch;
          JumpTarget <= Ir[25:0];
          BrOffset   <= {{16{Ir[15]}}, Ir[15:0]};
          if (cls_branch == BR_JR) JrTarget <= RsData;
          if (cls_exec) begin
            ExeReq <= 1'b1;
            state  <= ST_EXEC;
          end else begin
            PcStep <= 1'b1;
            state  <= ST_UPDATE;
          end
        end
        ST_EXEC: begin
          if (ExeDone) begin
            ExeReq <= 1'b0;
            PcSel  <= (Branch == BR_BEQ) ? AluZero :
                      (Branch == BR_BNE) ? ~AluZero : 1'b0;
            PcStep <= 1'b1;
            state  <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          PcStep     <= 1'b0;
          Branch     <= BR_SEQ;
          PcSel      <= 1'b0;
          InstrCount <= InstrCount + 32'd1;
          state      <= ST_FETCH;
        end
        ST_FAULT: begin
          ImemReq <= 1'b0;
          ExeReq  <= 1'b0;
          PcStep  <= 1'b0;
          Fault   <= 1'b1;
        end
        default: state <= ST_FAULT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - Directed self-checking bench for pc_sequencer with an instruction-level model
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cur_pc;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] rs_data;
  logic        exe_done;
  logic        alu_zero;

  logic        ImemReq, ExeReq, PcStep, PcSel, Fault;
  logic [31:0] ImemAddr, BrOffset, JrTarget, Ir, InstrCount;
  logic [2:0]  Branch;
  logic [25:0] JumpTarget;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] m_instr = 32'h0;
  logic [31:0] m_rs = 32'h0;
  bit          m_zero = 1'b0;
  int          m_count = 0;

  int          s_lat;
  bit          s_exe;
  logic [2:0]  s_br;
  logic        s_sel;
  logic [25:0] s_jt;
  logic [31:0] s_bo, s_jr;

  pc_sequencer dut (
    .Clk        (clk),
    .ReSet_n    (rst_n),
    .CurPc      (cur_pc),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemAck    (imem_ack),
    .ImemData   (imem_data),
    .RsData     (rs_data),
    .ExeReq     (ExeReq),
    .ExeDone    (exe_done),
    .AluZero    (alu_zero),
    .PcStep     (PcStep),
    .Branch     (Branch),
    .PcSel      (PcSel),
    .JumpTarget (JumpTarget),
    .BrOffset   (BrOffset),
    .JrTarget   (JrTarget),
    .Ir         (Ir),
    .InstrCount (InstrCount),
    .Fault      (Fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Instruction-level view of the classification rules
  function automatic logic [2:0] mdl_branch(input logic [31:0] i);
    logic [5:0] op;
    op = i[31:26];
    if (op == 6'd2) return 3'b011;
    if (op == 6'd0 && i[5:0] == 6'd8) return 3'b111;
    if (op == 6'd4) return 3'b010;
    if (op == 6'd5) return 3'b001;
    return 3'b000;
  endfunction

  function automatic bit mdl_exec(input logic [31:0] i);
    return !(mdl_branch(i) == 3'b011 || mdl_branch(i) == 3'b111);
  endfunction

  function automatic bit mdl_sel(input logic [31:0] i, input bit z);
    if (i[31:26] == 6'd4) return z;
    if (i[31:26] == 6'd5) return !z;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      m_count = 0;
    end else begin
      chk("instr_count", InstrCount, m_count);
      if (ImemReq) chk("imem_addr", ImemAddr, cur_pc);
      if (Fault) chk("fault_quiet", {29'd0, ImemReq, ExeReq, PcStep}, 32'd0);
      if (ExeReq && !mdl_exec(m_instr)) chk("exe_req_on_jump", {31'd0, ExeReq}, 32'd0);
      if (PcStep) begin
        chk("step_branch", {29'd0, Branch}, {29'd0, mdl_branch(m_instr)});
        chk("step_pcsel", {31'd0, PcSel}, {31'd0, mdl_sel(m_instr, m_zero)});
        chk("step_jtarget", {6'd0, JumpTarget}, {6'd0, m_instr[25:0]});
        chk("step_broffset", BrOffset, {{16{m_instr[15]}}, m_instr[15:0]});
        if (mdl_branch(m_instr) == 3'b111) chk("step_jrtarget", JrTarget, m_rs);
        chk("step_no_req", {30'd0, ImemReq, ExeReq}, 32'd0);
        m_count++;
      end
    end
  end

  task automatic run_instr(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rs,
                           input bit zero, input int ack_dly, input int done_dly);
    int n;
    int ack_cyc;
    cur_pc = pc; m_instr = instr; m_rs = rs; m_zero = zero;
    rs_data = rs; alu_zero = zero; s_exe = 1'b0; s_lat = -1;
    n = 0;
    while (!ImemReq && n < 40) begin @(negedge clk); n++; end
    chk("imem_req_seen", {31'd0, ImemReq}, 32'd1);
    if (!ImemReq) return;
    repeat (ack_dly) @(negedge clk);
    imem_ack = 1'b1; imem_data = instr; ack_cyc = cyc;
    @(negedge clk);
    imem_ack = 1'b0; imem_data = 32'hDEAD_BEEF;
    chk("imem_req_drop", {31'd0, ImemReq}, 32'd0);
    s_exe = ExeReq;
    if (mdl_exec(instr)) begin
      n = 0;
      while (!ExeReq && n < 40) begin @(negedge clk); n++; end
      chk("exe_req_seen", {31'd0, ExeReq}, 32'd1);
      if (!ExeReq) return;
      s_exe = 1'b1;
      repeat (done_dly) @(negedge clk);
      exe_done = 1'b1;
      @(negedge clk);
      exe_done = 1'b0;
      chk("exe_req_drop", {31'd0, ExeReq}, 32'd0);
    end
    n = 0;
    while (!PcStep && n < 40) begin s_exe |= ExeReq; @(negedge clk); n++; end
    chk("pc_step_seen", {31'd0, PcStep}, 32'd1);
    if (!PcStep) return;
    s_lat = cyc - ack_cyc;
    s_br = Branch; s_sel = PcSel; s_jt = JumpTarget; s_bo = BrOffset; s_jr = JrTarget;
    @(negedge clk);
    chk("pc_step_single", {31'd0, PcStep}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; cur_pc = 32'h3000; imem_ack = 1'b0; imem_data = 32'h0;
    rs_data = 32'h0; exe_done = 1'b0; alu_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", {31'd0, ImemReq}, 32'd0);
    chk("rst_imem_addr", ImemAddr, 32'h0000_3000);
    chk("rst_exe_req", {31'd0, ExeReq}, 32'd0);
    chk("rst_pc_step", {31'd0, PcStep}, 32'd0);
    chk("rst_branch_sel", {28'd0, Branch, PcSel}, 32'd0);
    chk("rst_targets", {6'd0, JumpTarget} | BrOffset | JrTarget, 32'd0);
    chk("rst_ir", Ir, 32'd0);
    chk("rst_count", InstrCount, 32'd0);
    chk("rst_fault", {31'd0, Fault}, 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {31'd0, ImemReq}, 32'd1);

    // addu r1,r2,r3
    run_instr(32'h3000, 32'h0043_0821, 32'h0, 1'b0, 2, 1);
    chk("addu_branch", {29'd0, s_br}, 32'd0);
    chk("addu_sel", {31'd0, s_sel}, 32'd0);
    chk("addu_exe", {31'd0, s_exe}, 32'd1);
    chk("addu_lat", s_lat, 32'd4);
    chk("addu_count", InstrCount, 32'd1);

    run_instr(32'h3004, 32'h0800_0C00, 32'h0, 1'b0, 0, 0);
    chk("j_branch", {29'd0, s_br}, 32'd3);
    chk("j_target", {6'd0, s_jt}, 32'h0000_0C00);
    chk("j_lat", s_lat, 32'd2);
    chk("j_no_exe", {31'd0, s_exe}, 32'd0);

    run_instr(32'h3008, 32'h1000_FFFE, 32'h0, 1'b1, 0, 0);
    chk("beq_branch", {29'd0, s_br}, 32'd2);
    chk("beq_sel", {31'd0, s_sel}, 32'd1);
    chk("beq_offset", s_bo, 32'hFFFF_FFFE);
    chk("beq_lat", s_lat, 32'd3);
    chk("branch_clear_fetch", {28'd0, Branch, PcSel}, 32'd0);

    // ack lands in the last cycle before timeout and must win
    run_instr(32'h300C, 32'h1400_0003, 32'h0, 1'b1, 14, 2);
    chk("bne_branch", {29'd0, s_br}, 32'd1);
    chk("bne_sel", {31'd0, s_sel}, 32'd0);
    chk("bne_offset", s_bo, 32'h0000_0003);
    chk("bne_no_fault", {31'd0, Fault}, 32'd0);

    run_instr(32'h3010, 32'h03E0_0008, 32'h0000_3010, 1'b0, 1, 0);
    chk("jr_branch", {29'd0, s_br}, 32'd7);
    chk("jr_target", s_jr, 32'h0000_3010);
    chk("jr_lat", s_lat, 32'd2);
    chk("jr_no_exe", {31'd0, s_exe}, 32'd0);
    chk("count_five", InstrCount, 32'd5);

    // reset pulse while a beq waits in EXEC
    cur_pc = 32'h3014; m_instr = 32'h1000_0001; m_zero = 1'b1; alu_zero = 1'b1;
    n = 0;
    while (!ImemReq && n < 40) begin @(negedge clk); n++; end
    imem_ack = 1'b1; imem_data = 32'h1000_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    n = 0;
    while (!ExeReq && n < 40) begin @(negedge clk); n++; end
    chk("mid_exe_req", {31'd0, ExeReq}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {28'd0, ImemReq, ExeReq, PcStep, Fault}, 32'd0);
    chk("mid_rst_branch", {28'd0, Branch, PcSel}, 32'd0);
    chk("mid_rst_ir", Ir, 32'd0);
    chk("mid_rst_addr", ImemAddr, 32'h0000_3000);
    chk("mid_rst_count", InstrCount, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'd0, ImemReq}, 32'd1);
    run_instr(32'h3014, 32'h0043_0821, 32'h0, 1'b0, 0, 0);
    chk("restart_count", InstrCount, 32'd1);

    // fetch timeout
    cur_pc = 32'h3018;
    n = 0;
    while (!ImemReq && n < 40) begin @(negedge clk); n++; end
    repeat (14) @(negedge clk);
    chk("to_not_yet", {30'd0, Fault, ImemReq}, 32'd1);
    @(negedge clk);
    chk("to_fault", {30'd0, Fault, ImemReq}, 32'd2);
    imem_ack = 1'b1; imem_data = 32'h0800_0000;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("to_ack_ignored", {29'd0, Fault, ImemReq, PcStep}, 32'd4);
    chk("to_count", InstrCount, 32'd1);

    // misaligned PC faults without issuing a request
    rst_n = 1'b0; cur_pc = 32'h3002;
    @(negedge clk);
    chk("rst_clears_fault", {31'd0, Fault}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("misalign_fault", {30'd0, Fault, ImemReq}, 32'd2);
    repeat (3) @(negedge clk);
    chk("misalign_hold", {30'd0, Fault, ImemReq}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
